// File: rtl/pw_lock_pkg.sv
// Shared types and width helpers for the pw_lock keypad code lock.
package pw_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_PROGRAM  = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  // Bits needed to hold values 0..val-1, never narrower than one bit.
  function automatic int clog2_min1(input int val);
    return (val <= 2) ? 1 : $clog2(val);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pw_lock_timer.sv
// Load/decrement/expire down-counter shared by the unlock and lockout windows.
module pw_lock_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pw_lock.sv
// Parametrised keypad code lock: digit entry, timed unlock, lockout after
// repeated failures, and code re-programming while unlocked.
module pw_lock
  import pw_lock_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h2034,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 1000,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   digit_valid,
  input  logic [DIGIT_W-1:0]                     digit,
  input  logic                                   clear,
  input  logic                                   prog,
  output logic                                   unlocked,
  output logic                                   fail,
  output logic                                   locked_out,
  output logic                                   prog_mode,
  output logic [pw_lock_pkg::clog2_min1(N_DIGITS+1)-1:0] digit_cnt
);

  localparam int CODE_W = N_DIGITS * DIGIT_W;
  localparam int CNT_W  = clog2_min1(N_DIGITS + 1);
  localparam int FCNT_W = clog2_min1(MAX_FAILS + 1);
  localparam int TMR_W  = clog2_min1(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES));

  localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(N_DIGITS - 1);
  localparam logic [FCNT_W-1:0] LAST_FAIL   = FCNT_W'(MAX_FAILS - 1);
  localparam logic [TMR_W-1:0]  UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                miss, miss_nx;
  logic [FCNT_W-1:0]   fail_cnt, fail_cnt_nx;
  logic                fail_nx;
  logic [CODE_W-1:0]   code, code_nx;
  logic [CODE_W-1:0]   shadow, shadow_nx, shadow_shift;
  logic                digit_miss;
  logic                tmr_load, tmr_run, tmr_expired;
  logic [TMR_W-1:0]    tmr_val;

  // Digit index 0 is the first-entered digit, held in the MS field.
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] c,
                                                    input logic [CNT_W-1:0]  idx);
    logic [CODE_W-1:0] sh;
    sh = c << (int'(idx) * DIGIT_W);
    return sh[CODE_W-1 -: DIGIT_W];
  endfunction

  assign digit_miss   = (digit != code_digit(code, cnt));
  assign shadow_shift = CODE_W'({shadow, digit});
  assign tmr_run      = (state == S_UNLOCKED) || (state == S_LOCKOUT);

  pw_lock_timer #(.WIDTH(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    miss_nx     = miss;
    fail_cnt_nx = fail_cnt;
    fail_nx     = 1'b0;
    code_nx     = code;
    shadow_nx   = shadow;
    tmr_load    = 1'b0;
    tmr_val     = UNLOCK_LOAD;
    unique case (state)
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          miss_nx  = 1'b0;
        end else if (digit_valid) begin
          // All digits are collected before judging, so the flag is sticky.
          if (cnt == LAST_IDX) begin
            cnt_nx  = '0;
            miss_nx = 1'b0;
            if (!((state == S_ENTRY && miss) || digit_miss)) begin
              state_nx    = S_UNLOCKED;
              fail_cnt_nx = '0;
              tmr_load    = 1'b1;
              tmr_val     = UNLOCK_LOAD;
            end else begin
              fail_nx     = 1'b1;
              fail_cnt_nx = fail_cnt + 1'b1;
              if (fail_cnt == LAST_FAIL) begin
                state_nx = S_LOCKOUT;
                tmr_load = 1'b1;
                tmr_val  = LOCK_LOAD;
              end else begin
                state_nx = S_IDLE;
              end
            end
          end else begin
            state_nx = S_ENTRY;
            cnt_nx   = cnt + 1'b1;
            miss_nx  = (state == S_ENTRY && miss) || digit_miss;
          end
        end
      end
      S_UNLOCKED: begin
        if (prog) begin
          state_nx = S_PROGRAM;
          cnt_nx   = '0;
        end else if (tmr_expired) begin
          state_nx = S_IDLE;
        end
      end
      S_PROGRAM: begin
        if (clear) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (digit_valid) begin
          shadow_nx = shadow_shift;
          if (cnt == LAST_IDX) begin
            code_nx  = shadow_shift;
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        if (tmr_expired) begin
          state_nx    = S_IDLE;
          fail_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        miss_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      miss     <= 1'b0;
      fail_cnt <= '0;
      fail     <= 1'b0;
      code     <= DEFAULT_CODE;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      miss     <= miss_nx;
      fail_cnt <= fail_cnt_nx;
      fail     <= fail_nx;
      code     <= code_nx;
    end
  end

  // Shadow is only read after being fully overwritten, so it needs no reset.
  always_ff @(posedge clk) begin
    shadow <= shadow_nx;
  end

  assign unlocked   = (state == S_UNLOCKED);
  assign locked_out = (state == S_LOCKOUT);
  assign prog_mode  = (state == S_PROGRAM);
  assign digit_cnt  = cnt;

endmodule
